ppb_host: RTL and testbench

PPB_HOST -- requirements
Module: ppb_host

---
 rtl/ppb_pkg.sv | 18 +
 rtl/ppb_host_clkgen.sv | 46 ++++
 rtl/ppb_host.sv | 170 +++++++++++++++++
 tb/tb_ppb_host.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppb_pkg.sv
// Shared state encoding and constants for the PPB host and its beat generator.
package ppb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ID_PHASE   = 2'd1,
    DATA_PHASE = 2'd2
  } ppb_state_e;

  localparam int          PPB_BLOCK_W    = 3;
  localparam int          PPB_ID_BEATS   = 8;
  localparam logic [22:0] PPB_PROJECT_ID = 23'h31c748;

  function automatic int ppb_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ppb_host_clkgen.sv
// Bus clock and beat strobes: beat_start marks the cycle before a beat's first visible cycle,
// beat_sample marks a beat's last visible cycle; free-running while i_run, no backpressure.
module ppb_host_clkgen
  import ppb_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_bus_clk,
  output logic o_beat_start,
  output logic o_beat_sample
);

  localparam int              CNT_W    = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_clk;
  logic             r_sample;

  // Bus clock and sample strobe are registered one cycle behind r_cnt, so the
  // pin outputs (also loaded on beat_start) line up with them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_bus_clk <= 1'b0;
      r_sample  <= 1'b0;
    end else if (!i_run) begin
      r_cnt     <= '0;
      r_bus_clk <= 1'b0;
      r_sample  <= 1'b0;
    end else begin
      r_cnt     <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_bus_clk <= (r_cnt >= CNT_HALF);
      r_sample  <= (r_cnt == CNT_LAST);
    end
  end

  assign o_bus_clk     = r_bus_clk;
  assign o_beat_start  = i_run && (r_cnt == '0);
  assign o_beat_sample = r_sample;

endmodule

// File: rtl/ppb_host.sv
// PPB bus host: 8-beat identity check then a data exchange; done at start+1+beats*2*CLK_DIV.
// No backpressure: start is only honoured in IDLE, requests while busy are dropped.
module ppb_host
  import ppb_pkg::*;
#(
  parameter int          INPUT_BLOCKS  = 20,
  parameter int          OUTPUT_BLOCKS = 40,
  parameter logic [22:0] PROJECT_ID    = PPB_PROJECT_ID,
  parameter int          CLK_DIV       = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [PPB_BLOCK_W*INPUT_BLOCKS-1:0]  wr_data,
  output logic [PPB_BLOCK_W*OUTPUT_BLOCKS-1:0] rd_data,
  output logic                                busy,
  output logic                                done,
  output logic                                id_error,
  output logic                                pmod_bus_clk,
  output logic                                pmod_bus_control,
  output logic [PPB_BLOCK_W-1:0]              pmod_bus_poti,
  input  logic [PPB_BLOCK_W-1:0]              pmod_bus_pito
);

  localparam int DATA_BEATS = ppb_max(INPUT_BLOCKS, OUTPUT_BLOCKS);
  localparam int BEAT_W     = $clog2(ppb_max(DATA_BEATS, PPB_ID_BEATS));
  localparam int ID_KEEP_W  = PPB_BLOCK_W * (PPB_ID_BEATS - 1);

  localparam logic [BEAT_W-1:0] ID_LAST   = BEAT_W'(PPB_ID_BEATS - 1);
  localparam logic [BEAT_W-1:0] DATA_LAST = BEAT_W'(DATA_BEATS - 1);

  ppb_state_e                         r_state;
  logic [BEAT_W-1:0]                  r_beat;
  logic                               r_busy;
  logic                               r_done;
  logic                               r_id_err;
  logic                               r_ctrl;
  logic [PPB_BLOCK_W-1:0]             r_poti;
  logic [PPB_BLOCK_W*INPUT_BLOCKS-1:0]  r_wr_shadow;
  logic [PPB_BLOCK_W*OUTPUT_BLOCKS-1:0] r_rd_shadow;
  logic [PPB_BLOCK_W*OUTPUT_BLOCKS-1:0] r_rd_data;
  logic [ID_KEEP_W-1:0]               r_id_word;

  ppb_state_e                         w_state_nxt;
  logic [BEAT_W-1:0]                  w_beat_nxt;
  logic                               w_finish;
  logic                               w_id_fail;
  logic [PPB_BLOCK_W-1:0]             w_poti_nxt;
  logic [PPB_BLOCK_W*OUTPUT_BLOCKS-1:0] w_rd_merged;
  logic                               w_bus_clk;
  logic                               w_beat_start;
  logic                               w_beat_sample;

  ppb_host_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk          (clk),
    .rst          (rst),
    .i_run        (r_busy),
    .o_bus_clk    (w_bus_clk),
    .o_beat_start (w_beat_start),
    .o_beat_sample(w_beat_sample)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_finish    = 1'b0;
    w_id_fail   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ID_PHASE;
          w_beat_nxt  = '0;
        end
      end
      ID_PHASE: begin
        if (w_beat_sample) begin
          if (r_beat == ID_LAST) begin
            w_beat_nxt = '0;
            // The final ID chunk is checked straight off the pins, never stored.
            if ({pmod_bus_pito, r_id_word} == {1'b0, PROJECT_ID}) begin
              w_state_nxt = DATA_PHASE;
            end else begin
              w_state_nxt = IDLE;
              w_id_fail   = 1'b1;
            end
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      DATA_PHASE: begin
        if (w_beat_sample) begin
          if (r_beat == DATA_LAST) begin
            w_state_nxt = IDLE;
            w_finish    = 1'b1;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sample of beat k and drive of beat k+1 share an edge, so drive uses the next index.
  always_comb begin
    w_rd_merged = r_rd_shadow;
    if (int'(r_beat) < OUTPUT_BLOCKS) begin
      w_rd_merged[int'(r_beat)*PPB_BLOCK_W +: PPB_BLOCK_W] = pmod_bus_pito;
    end
    w_poti_nxt = '0;
    if ((w_state_nxt == DATA_PHASE) && (int'(w_beat_nxt) < INPUT_BLOCKS)) begin
      w_poti_nxt = r_wr_shadow[int'(w_beat_nxt)*PPB_BLOCK_W +: PPB_BLOCK_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_id_err    <= 1'b0;
      r_ctrl      <= 1'b0;
      r_poti      <= '0;
      r_wr_shadow <= '0;
      r_rd_shadow <= '0;
      r_rd_data   <= '0;
      r_id_word   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_done  <= w_finish | w_id_fail;
      if ((r_state == IDLE) && start) begin
        r_wr_shadow <= wr_data;
        r_busy      <= 1'b1;
        r_id_err    <= 1'b0;
      end
      if (w_id_fail) begin
        r_id_err <= 1'b1;
        r_busy   <= 1'b0;
      end
      if (w_finish) begin
        r_busy    <= 1'b0;
        r_rd_data <= w_rd_merged;
      end
      if ((r_state == ID_PHASE) && w_beat_sample && (r_beat != ID_LAST)) begin
        r_id_word[int'(r_beat)*PPB_BLOCK_W +: PPB_BLOCK_W] <= pmod_bus_pito;
      end
      if ((r_state == DATA_PHASE) && w_beat_sample) begin
        r_rd_shadow <= w_rd_merged;
      end
      if (w_beat_start) begin
        r_ctrl <= (w_state_nxt == ID_PHASE);
        r_poti <= w_poti_nxt;
      end
    end
  end

  assign rd_data          = r_rd_data;
  assign busy             = r_busy;
  assign done             = r_done;
  assign id_error         = r_id_err;
  assign pmod_bus_clk     = w_bus_clk;
  assign pmod_bus_control = r_ctrl;
  assign pmod_bus_poti    = r_poti;

endmodule

// File: tb/tb_ppb_host.sv
// Directed bench for ppb_host: transaction table plus reset, ignored-start and divider sequences.
module tb_ppb_host;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         start1 = 1'b0;
  logic [59:0]  wr_data = '0;
  logic [119:0] rd_data, rd_data1;
  logic         busy, done, id_error, bus_clk, bus_ctrl;
  logic         busy1, done1, id_error1, bus_clk1, bus_ctrl1;
  logic [2:0]   poti, poti1;
  logic [2:0]   pito = '0;
  logic [2:0]   pito1 = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ppb_host dut (
    .clk(clk), .rst(rst), .start(start), .wr_data(wr_data), .rd_data(rd_data),
    .busy(busy), .done(done), .id_error(id_error), .pmod_bus_clk(bus_clk),
    .pmod_bus_control(bus_ctrl), .pmod_bus_poti(poti), .pmod_bus_pito(pito)
  );

  ppb_host #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .wr_data(wr_data), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .id_error(id_error1), .pmod_bus_clk(bus_clk1),
    .pmod_bus_control(bus_ctrl1), .pmod_bus_poti(poti1), .pmod_bus_pito(pito1)
  );

  // Device model: beats are tracked from bus clock rising edges, pito set mid-beat.
  logic [23:0] dev_id = 24'h31c748;
  int          dev_off = 0;
  int          dev_k = 0;
  logic        dev_in_id = 1'b0;
  logic [2:0]  poti_log [64];

  always @(posedge bus_clk) begin
    if (bus_ctrl) begin
      if (!dev_in_id || dev_k == 7) dev_k = 0;
      else dev_k = dev_k + 1;
      dev_in_id = 1'b1;
      pito = dev_id[dev_k*3 +: 3];
    end else begin
      if (dev_in_id) begin
        dev_in_id = 1'b0;
        dev_k = 0;
      end else begin
        dev_k = dev_k + 1;
      end
      if (dev_k < 64) poti_log[dev_k] = poti;
      pito = 3'((dev_k + dev_off) % 8);
    end
  end

  logic [23:0] nom_id = 24'h31c748;
  int          k1 = 0;
  logic        in1 = 1'b0;

  always @(posedge bus_clk1) begin
    if (bus_ctrl1) begin
      if (!in1 || k1 == 7) k1 = 0;
      else k1 = k1 + 1;
      in1 = 1'b1;
      pito1 = nom_id[k1*3 +: 3];
    end else begin
      if (in1) begin
        in1 = 1'b0;
        k1 = 0;
      end else begin
        k1 = k1 + 1;
      end
      pito1 = 3'(k1 % 8);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [119:0] exp_rd(input int off);
    logic [119:0] r;
    r = '0;
    for (int k = 0; k < 40; k++) r[k*3 +: 3] = 3'((k + off) % 8);
    return r;
  endfunction

  function automatic logic [2:0] exp_poti(input logic [59:0] w, input int k);
    return (k < 20) ? w[k*3 +: 3] : 3'b000;
  endfunction

  function automatic int poti_errs(input logic [59:0] w);
    int e;
    e = 0;
    for (int k = 0; k < 40; k++) if (poti_log[k] !== exp_poti(w, k)) e++;
    return e;
  endfunction

  // Called on the negedge after the start-sampling edge; counts edges until done.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic run_txn(input logic [23:0] id, input logic [59:0] wr, input int off,
                         output int cyc);
    dev_id  = id;
    dev_off = off;
    @(negedge clk);
    wr_data = wr;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
  endtask

  typedef struct {
    logic [23:0] id;
    logic [59:0] wr;
    int          off;
    logic        err;
    int          cyc;
  } vec_t;

  vec_t         vecs [6];
  logic [119:0] rd_exp;
  logic [59:0]  wr_a;
  int           cyc, n, ndone, nontog;
  logic         prev_clk;

  initial begin
    vecs[0] = '{24'h31c748, 60'h0123456789ABCDE, 0, 1'b0, 385};
    vecs[1] = '{24'h000001, 60'h0FFFFFFFFFFFFFF, 3, 1'b1, 65};
    vecs[2] = '{24'h31c748, 60'hFEDCBA987654321, 5, 1'b0, 385};
    vecs[3] = '{24'hB1C748, 60'h0123456789ABCDE, 1, 1'b1, 65};
    vecs[4] = '{24'h31c749, 60'h0123456789ABCDE, 6, 1'b1, 65};
    vecs[5] = '{24'h31c748, 60'h555555555555555, 7, 1'b0, 385};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_id_error", id_error, 1'b0);
    check("rst_rd_data", rd_data, '0);
    check("rst_bus_clk", bus_clk, 1'b0);
    check("rst_control", bus_ctrl, 1'b0);
    check("rst_poti", poti, 3'b000);
    rst = 1'b1;

    rd_exp = '0;
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].id, vecs[i].wr, vecs[i].off, cyc);
      check("txn_cycles", cyc, vecs[i].cyc);
      check("txn_id_error", id_error, vecs[i].err);
      check("txn_busy_low", busy, 1'b0);
      if (!vecs[i].err) rd_exp = exp_rd(vecs[i].off);
      check("txn_rd_data", rd_data, rd_exp);
      if (!vecs[i].err) check("txn_poti_path", poti_errs(vecs[i].wr), 0);
      if (i == 0) check("rd_block5", rd_data[17:15], 3'd5);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("idle_control", bus_ctrl, 1'b0);
    end

    // Second start during data beat 10 and a late wr_data change are both ignored.
    wr_a    = 60'h0123456789ABCDE;
    dev_id  = 24'h31c748;
    dev_off = 2;
    @(negedge clk);
    wr_data = wr_a;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    wr_data = 60'hFEDCBA987654321;
    n = 0;
    while (!(busy && !dev_in_id && dev_k == 10) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_beat10", n < 1000, 1'b1);
    start = 1'b1;
    ndone = 0;
    @(negedge clk);
    if (done) ndone++;
    start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("single_done", ndone, 1);
    check("captured_wr_only", poti_errs(wr_a), 0);
    check("ignored_rd_data", rd_data, exp_rd(2));

    // Reset in data beat 15 aborts, then start on the first cycle after release.
    dev_id  = 24'h31c748;
    dev_off = 4;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(busy && !dev_in_id && dev_k == 15) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_beat15", n < 1000, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_rd_data", rd_data, '0);
    check("abort_bus_clk", bus_clk, 1'b0);
    check("abort_control", bus_ctrl, 1'b0);
    check("abort_poti", poti, 3'b000);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    dev_off = 1;
    wr_data = 60'h0123456789ABCDE;
    rst     = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("post_rst_cycles", cyc, 385);
    check("post_rst_id_error", id_error, 1'b0);
    check("post_rst_rd_data", rd_data, exp_rd(1));

    // CLK_DIV=1 instance.
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1   = 1'b0;
    cyc      = 0;
    nontog   = 0;
    prev_clk = 1'b0;
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc >= 2 && cyc <= 12 && bus_clk1 == prev_clk) nontog++;
      prev_clk = bus_clk1;
      if (done1) break;
    end
    check("div1_toggle", nontog, 0);
    check("div1_cycles", cyc, 97);
    check("div1_id_error", id_error1, 1'b0);
    check("div1_rd_data", rd_data1, exp_rd(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
